// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: pointer width, depth and Gray-to-binary decode.
// Used by the write-side full controller and the read-side empty controller.
package async_fifo_pkg;

  // Pointer width: one extra wrap bit above the address.
  function automatic int unsigned ptr_w(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  // FIFO depth in entries.
  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'(1) << addr_width;
  endfunction

  // Gray-to-binary over a 32-bit container; callers zero-extend and truncate.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/wr_full_ctrl_if.sv
// Producer-facing write handshake/status bundle of the async FIFO write side.
//   master : producer (drives wr_req, ovf_clr; observes status)
//   slave  : wr_full_ctrl (drives wr_en and all status flags)
interface wr_full_ctrl_if
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
);

  logic                           wr_req;
  logic                           ovf_clr;
  logic                           wr_en;
  logic                           wr_full;
  logic                           wr_almost_full;
  logic [ptr_w(ADDR_WIDTH)-1:0]   wr_level;
  logic                           wr_overflow;

  modport master (
    output wr_req, ovf_clr,
    input  wr_en, wr_full, wr_almost_full, wr_level, wr_overflow
  );

  modport slave (
    input  wr_req, ovf_clr,
    output wr_en, wr_full, wr_almost_full, wr_level, wr_overflow
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, reset to zero. Shared by both FIFO clock domains.
//   clk, rst_n : destination clock, async active-low reset
//   d          : source-domain bus (must be Gray coded by the caller)
//   q          : synchronized bus, two edges of latency
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  // Back-to-back stages with nothing between them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/wr_full_ctrl.sv
// Write-side status controller of the async FIFO. Synchronizes the Gray read
// pointer, registers FULL / level / almost-full / sticky overflow, and
// qualifies the producer request into wr_en.
// Optional build macro: ASYNC_FIFO_ALMOST_FULL_EN (almost-full flag present;
// when undefined wr_almost_full is tied low and AF_MARGIN is ignored).
// Ports:
//   wr_clk, rst_n      : write clock, async active-low reset
//   bus (slave)        : wr_req/ovf_clr in; wr_en, wr_full, wr_almost_full,
//                        wr_level, wr_overflow out
//   rd_ptr_gray        : Gray read pointer from rd_clk domain (unsynchronized)
//   wr_ptr_bin         : current binary write pointer
//   wr_ptr_gray_next   : next Gray write pointer, already including wr_en
module wr_full_ctrl
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_MARGIN  = 2
) (
  input  logic                         wr_clk,
  input  logic                         rst_n,
  wr_full_ctrl_if.slave                bus,
  input  logic [ptr_w(ADDR_WIDTH)-1:0] rd_ptr_gray,
  input  logic [ptr_w(ADDR_WIDTH)-1:0] wr_ptr_bin,
  input  logic [ptr_w(ADDR_WIDTH)-1:0] wr_ptr_gray_next
);

  localparam int unsigned PW    = ptr_w(ADDR_WIDTH);
  localparam int unsigned DEPTH = depth(ADDR_WIDTH);

  // Elaboration-time parameter sanity.
  if (ADDR_WIDTH < 2) begin : g_bad_addr_width
    $error("wr_full_ctrl: ADDR_WIDTH must be >= 2");
  end
  if (AF_MARGIN < 1 || AF_MARGIN >= DEPTH) begin : g_bad_af_margin
    $error("wr_full_ctrl: AF_MARGIN must be in 1 .. DEPTH-1");
  end

  logic [PW-1:0] rq2;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] level_nxt;
  logic [PW-1:0] full_pattern;
  logic          full_nxt;
  logic          full_q;
  logic [PW-1:0] level_q;
  logic          ovf_q;

  sync_2ff #(
    .WIDTH (PW)
  ) u_rptr_sync (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .d     (rd_ptr_gray),
    .q     (rq2)
  );

  // Qualified write uses only the registered flag, so there is no comb loop.
  assign bus.wr_en = bus.wr_req & ~full_q;

  // Full when the next write pointer equals the read pointer with both MSBs
  // inverted (Gray form of "one full lap ahead").
  assign full_pattern = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
  assign full_nxt     = (wr_ptr_gray_next == full_pattern);

  // Occupancy modulo 2**PW; wrap is handled by the natural overflow.
  assign rd_bin    = PW'(gray2bin(32'(rq2)));
  assign bin_next  = wr_ptr_bin + PW'(bus.wr_en);
  assign level_nxt = bin_next - rd_bin;

  // Status registers; overflow set has priority over clear.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_nxt;
      level_q <= level_nxt;
      if (bus.wr_req & full_q) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
  localparam int unsigned AF_THRESH = DEPTH - AF_MARGIN;

  logic af_q;

  // Almost-full stays asserted while full since level >= threshold.
  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      af_q <= 1'b0;
    end else begin
      af_q <= (level_nxt >= PW'(AF_THRESH));
    end
  end

  assign bus.wr_almost_full = af_q;
`else
  assign bus.wr_almost_full = 1'b0;
`endif

  assign bus.wr_full     = full_q;
  assign bus.wr_level    = level_q;
  assign bus.wr_overflow = ovf_q;

endmodule
